pmp_fifo_bridge: RTL and testbench
==================================

// Module: pmp_fifo_bridge
// PURPOSE
//  Synchronous, parametrised bridge between the ADC capture FIFOs and the PIC parallel master port (PMP).
//  On each PIC data request, picks a channel round-robin and pulses that FIFO's read clock.
//  After a settle time it presents the sample with a ready flag, and holds it until the request drops.
//  Adds multi-channel arbitration, a request timeout, an abort path and a transfer counter.
// PARAMETERS
//  DATA_W     8     sample width per channel and PMP data width
//  N_CH       2     number of ADC FIFO channels (>=1); CH_W = max(1,$clog2(N_CH))
//  RDCK_HIGH  2     fifo_rdck high time, clock cycles (>=1)
//  SETTLE     1     cycles after rdck falls before adc_data is sampled (>=0)
//  TIMEOUT    1023  cycles in ARB with no channel ready before pmp_timeout sets (>=1)
//  CNT_W      16    width of xfer_count
// PORTS
//  clock        in   1             system clock, all logic on rising edge
//  reset        in   1             asynchronous, active-high reset
//  adc_data     in   N_CH*DATA_W   FIFO read data; channel c at [c*DATA_W +: DATA_W]
//  fifo_rden    in   N_CH          per-channel data-available (FIFO not empty)
//  fifo_rdck    out  N_CH          per-channel FIFO read clock pulse, registered
//  pmp_dreq     in   1             PIC data request, asynchronous to clock
//  pmp_d        out  DATA_W        data to PIC, registered
//  pmp_drdy     out  1             data valid to PIC, registered
//  pmp_ch       out  CH_W          channel of the sample on pmp_d
//  pmp_timeout  out  1             no channel ready for TIMEOUT cycles while requested
//  drop_pulse   out  1             1-cycle pulse: sample read from FIFO but discarded
//  xfer_count   out  CNT_W         count of completed transfers, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=N_CH-1 (first grant goes to ch0); sync flops 0.
//  pmp_dreq passes through a 2-flop synchroniser -> dreq_s. fifo_rden is used unsynchronised (same clock domain).
//  FSM states and transitions:
//   IDLE:   pmp_d=0, pmp_drdy=0, pmp_timeout=0. Moves to ARB when dreq_s=1.
//   ARB:    if dreq_s=0 -> IDLE (no FIFO access).
//           Else if any fifo_rden: grant the first set bit searching from rr+1 upward, with wrap.
//           On grant, latch ch, set rr=ch, and go to RDCK.
//           Else increment tmo_cnt; when it reaches TIMEOUT, set pmp_timeout and stay in ARB.
//           pmp_timeout stays set until IDLE. tmo_cnt clears on leaving ARB.
//   RDCK:   fifo_rdck[ch]=1 for exactly RDCK_HIGH cycles; all other rdck bits 0. Then go to SETTLE.
//   SETTLE: all rdck bits 0 for SETTLE cycles. SETTLE=0 skips this state. Then go to CAPTURE.
//   CAPTURE (1 cycle): if dreq_s=1, register adc_data slice ch into pmp_d, set pmp_ch=ch, drdy=1,
//           xfer_count+=1, go to HOLD. If dreq_s=0, drop_pulse=1 for 1 cycle and go to IDLE.
//   HOLD:   pmp_d, pmp_ch and drdy stay stable. When dreq_s=0, go to IDLE (d and drdy cleared next edge).
//  Abort handling: dreq_s falling during RDCK or SETTLE does not truncate the rdck pulse.
//   The sequence completes and the sample is dropped at CAPTURE.
//  Latency: dreq rising sampled at edge k, channel ready -> dreq_s=1 after k+1, ARB at k+2.
//   fifo_rdck high from edge k+3 for RDCK_HIGH cycles; drdy=1 after edge k+3+RDCK_HIGH+SETTLE+1.
//   With default parameters, drdy rises at edge k+7.
//  At most one rdck bit is ever high. Exactly one FIFO read occurs per grant.
//  xfer_count wraps from 2^CNT_W-1 to 0. Drops are not counted.
//  Async reset mid-transfer forces rdck and drdy to 0 immediately. rr and xfer_count return to their reset values.
// TESTING
//  1. Defaults, rden=2'b01, adc_data ch0=8'hA5, dreq pulse -> rdck[0] high 2 cycles,
//     pmp_d=8'hA5 with pmp_ch=0 and drdy=1 at edge k+7, then d=0 and drdy=0 after dreq falls.
//  2. rden=2'b11, 4 requests -> grants ch0,ch1,ch0,ch1; xfer_count=4.
//  3. rden=0, dreq held, TIMEOUT=15 -> pmp_timeout rises 15 cycles after ARB entry and no rdck pulses.
//     Set rden[1] -> ch1 served, timeout stays set until IDLE.
//  4. dreq drops during RDCK -> full 2-cycle rdck pulse, drop_pulse=1 once, drdy stays 0, count unchanged.
//  5. CNT_W=2, 5 transfers -> xfer_count sequence 1,2,3,0,1.
//  6. reset asserted in SETTLE -> all outputs 0 asynchronously; next request is granted to ch0.

Source files
------------

// File: rtl/pmp_fifo_bridge.sv
// pmp_fifo_bridge: round-robin ADC FIFO reader that hands samples to a PIC parallel master port
module pmp_fifo_bridge #(
    parameter int DATA_W    = 8,
    parameter int N_CH      = 2,
    parameter int RDCK_HIGH = 2,
    parameter int SETTLE    = 1,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] adc_data,
    input  logic [N_CH-1:0]        fifo_rden,
    output logic [N_CH-1:0]        fifo_rdck,
    input  logic                   pmp_dreq,
    output logic [DATA_W-1:0]      pmp_d,
    output logic                   pmp_drdy,
    output logic [CH_W-1:0]        pmp_ch,
    output logic                   pmp_timeout,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       xfer_count
);
    localparam int PMAX = (RDCK_HIGH > SETTLE) ? RDCK_HIGH : SETTLE;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARB, RDCK, SETL, CAPT, HOLD} state_t;

    state_t              state;
    logic                dreq_m;
    logic                dreq_s;
    logic [CH_W-1:0]     rr;
    logic [CH_W-1:0]     gnt;
    logic [DATA_W-1:0]   sel;
    logic [PW-1:0]       ph;
    logic [TW-1:0]       tmo_cnt;

    // two-flop synchroniser for the PIC request, which arrives asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dreq_m <= 1'b0;
            dreq_s <= 1'b0;
        end else begin
            dreq_m <= pmp_dreq;
            dreq_s <= dreq_m;
        end
    end

    // round-robin pick starting just after the last granted channel; lowest offset wins
    always_comb begin
        gnt = rr;
        sel = adc_data[DATA_W-1:0];
        for (int i = N_CH; i >= 1; i--)
            if (fifo_rden[CH_W'((int'(rr) + i) % N_CH)]) gnt = CH_W'((int'(rr) + i) % N_CH);
        for (int c = 0; c < N_CH; c++)
            if (CH_W'(c) == rr) sel = adc_data[c*DATA_W +: DATA_W];
    end

    // transfer sequencer: arbitrate, pulse the read clock, settle, capture, hold for the PIC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr          <= CH_W'(N_CH - 1);
            ph          <= '0;
            tmo_cnt     <= '0;
            fifo_rdck   <= '0;
            pmp_d       <= '0;
            pmp_drdy    <= 1'b0;
            pmp_ch      <= '0;
            pmp_timeout <= 1'b0;
            drop_pulse  <= 1'b0;
            xfer_count  <= '0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                IDLE: if (dreq_s) state <= ARB;
                ARB: begin
                    if (!dreq_s) begin
                        tmo_cnt     <= '0;
                        pmp_timeout <= 1'b0;
                        state       <= IDLE;
                    end else if (|fifo_rden) begin
                        rr        <= gnt;
                        fifo_rdck <= N_CH'(1) << gnt;
                        ph        <= '0;
                        tmo_cnt   <= '0;
                        state     <= RDCK;
                    end else begin
                        if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TW'(TIMEOUT - 1)) pmp_timeout <= 1'b1;
                    end
                end
                RDCK: begin
                    if (ph == PW'(RDCK_HIGH - 1)) begin
                        fifo_rdck <= '0;
                        ph        <= '0;
                        state     <= (SETTLE == 0) ? CAPT : SETL;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                SETL: begin
                    if (ph == PW'(SETTLE - 1)) begin
                        ph    <= '0;
                        state <= CAPT;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                CAPT: begin
                    if (dreq_s) begin
                        pmp_d      <= sel;
                        pmp_ch     <= rr;
                        pmp_drdy   <= 1'b1;
                        xfer_count <= xfer_count + 1'b1;
                        state      <= HOLD;
                    end else begin
                        drop_pulse  <= 1'b1;
                        pmp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (!dreq_s) begin
                        pmp_d       <= '0;
                        pmp_drdy    <= 1'b0;
                        pmp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_fifo_bridge.sv
// tb_pmp_fifo_bridge: directed and randomized checks of pmp_fifo_bridge against a timestamp-based model
module tb_pmp_fifo_bridge;
    localparam int N_CH = 2;
    localparam int RH   = 2;
    localparam int ST   = 1;
    localparam int TMO  = 15;
    localparam int CW   = 2;
    localparam int M_IDLE = 0, M_ARB = 1, M_BUSY = 2, M_HOLD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adc_data = '0;
    logic [1:0]  fifo_rden = '0;
    logic [1:0]  fifo_rdck;
    logic        pmp_dreq = 1'b0;
    logic [7:0]  pmp_d;
    logic        pmp_drdy;
    logic [0:0]  pmp_ch;
    logic        pmp_timeout;
    logic        drop_pulse;
    logic [1:0]  xfer_count;

    int checks = 0;
    int failures = 0;

    pmp_fifo_bridge #(
        .DATA_W(8), .N_CH(N_CH), .RDCK_HIGH(RH), .SETTLE(ST), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .adc_data(adc_data), .fifo_rden(fifo_rden),
        .fifo_rdck(fifo_rdck), .pmp_dreq(pmp_dreq), .pmp_d(pmp_d), .pmp_drdy(pmp_drdy),
        .pmp_ch(pmp_ch), .pmp_timeout(pmp_timeout), .drop_pulse(drop_pulse), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic wait_drdy(input logic lvl, input string nm);
        int n = 0;
        while (pmp_drdy !== lvl && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(nm, pmp_drdy, lvl);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        pmp_dreq = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
    endtask

    // reference model: a request is granted at edge g; the read clock is high after edges g..g+RH-1,
    // and the capture decision is taken at edge g+RH+ST+1 using the synchronised request
    int unsigned cyc = 0;
    int unsigned m_g = 0;
    int          m_mode = M_IDLE;
    int          m_rr = N_CH - 1;
    int          m_wait = 0;
    int          pick;
    logic        m_q1 = 1'b0, m_s = 1'b0, m_old = 1'b0;
    logic [1:0]  e_rdck = '0;
    logic [7:0]  e_d = '0;
    logic        e_drdy = 1'b0, e_ch = 1'b0, e_tmo = 1'b0, e_drop = 1'b0;
    logic [1:0]  e_cnt = '0;

    initial forever begin
        @(posedge clock or posedge reset);
        cyc++;
        if (reset) begin
            m_mode = M_IDLE; m_rr = N_CH - 1; m_wait = 0; m_q1 = 1'b0; m_s = 1'b0;
            e_rdck = '0; e_d = '0; e_drdy = 1'b0; e_ch = 1'b0; e_tmo = 1'b0; e_drop = 1'b0; e_cnt = '0;
        end else begin
            m_old = m_s;
            m_s = m_q1;
            m_q1 = pmp_dreq;
            e_drop = 1'b0;
            if (m_mode == M_IDLE) begin
                if (m_old) begin m_mode = M_ARB; m_wait = 0; end
            end else if (m_mode == M_ARB) begin
                if (!m_old) begin
                    m_mode = M_IDLE;
                    e_tmo = 1'b0;
                end else if (fifo_rden != 0) begin
                    pick = -1;
                    for (int off = 1; off <= N_CH; off++)
                        if (pick < 0 && fifo_rden[(m_rr + off) % N_CH]) pick = (m_rr + off) % N_CH;
                    m_rr = pick;
                    m_g = cyc;
                    m_mode = M_BUSY;
                end else begin
                    m_wait++;
                    if (m_wait >= TMO) e_tmo = 1'b1;
                end
            end else if (m_mode == M_BUSY) begin
                if (cyc == m_g + RH + ST + 1) begin
                    if (m_old) begin
                        e_d = adc_data[m_rr*8 +: 8];
                        e_ch = 1'(m_rr);
                        e_drdy = 1'b1;
                        e_cnt++;
                        m_mode = M_HOLD;
                    end else begin
                        e_drop = 1'b1;
                        e_tmo = 1'b0;
                        m_mode = M_IDLE;
                    end
                end
            end else if (!m_old) begin
                e_d = '0; e_drdy = 1'b0; e_tmo = 1'b0; m_mode = M_IDLE;
            end
            e_rdck = (m_mode == M_BUSY && cyc - m_g < RH) ? 2'(1 << m_rr) : 2'b00;
        end
    end

    // per-cycle comparison of every output against the model, away from the rising edge
    initial forever begin
        @(negedge clock);
        chk("cyc_rdck", fifo_rdck, e_rdck);
        chk("cyc_drdy", pmp_drdy, e_drdy);
        chk("cyc_d", pmp_d, e_d);
        chk("cyc_tmo", pmp_timeout, e_tmo);
        chk("cyc_drop", drop_pulse, e_drop);
        chk("cyc_cnt", xfer_count, e_cnt);
        if (e_drdy) chk("cyc_ch", pmp_ch, e_ch);
    end

    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_rdck", fifo_rdck, 0);
        chk("rst_d", pmp_d, 0);
        chk("rst_drdy", pmp_drdy, 0);
        chk("rst_ch", pmp_ch, 0);
        chk("rst_tmo", pmp_timeout, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_cnt", xfer_count, 0);
        #2 reset = 1'b0;
        @(negedge clock);

        // single transfer latency from ch0
        fifo_rden = 2'b01;
        adc_data = 16'h00A5;
        pmp_dreq = 1'b1;
        repeat (4) @(negedge clock);
        chk("t1_rdck_k3", fifo_rdck, 2'b01);
        @(negedge clock); chk("t1_rdck_k4", fifo_rdck, 2'b01);
        @(negedge clock); chk("t1_rdck_k5", fifo_rdck, 2'b00);
        @(negedge clock); chk("t1_drdy_k6", pmp_drdy, 0);
        @(negedge clock);
        chk("t1_drdy_k7", pmp_drdy, 1);
        chk("t1_d_k7", pmp_d, 8'hA5);
        chk("t1_ch_k7", pmp_ch, 0);
        chk("t1_cnt", xfer_count, 1);
        pmp_dreq = 1'b0;
        wait_drdy(1'b0, "t1_drdy_fall");
        chk("t1_d_clear", pmp_d, 0);

        // alternating grants and counter wrap
        pulse_reset();
        fifo_rden = 2'b11;
        adc_data = 16'h3C5A;
        for (int i = 0; i < 5; i++) begin
            pmp_dreq = 1'b1;
            wait_drdy(1'b1, "t2_drdy_rise");
            chk("t2_ch", pmp_ch, i % 2);
            chk("t2_d", pmp_d, (i % 2) ? 8'h3C : 8'h5A);
            chk("t2_cnt", xfer_count, exp_cnt[i]);
            pmp_dreq = 1'b0;
            wait_drdy(1'b0, "t2_drdy_fall");
            repeat (2) @(negedge clock);
        end

        // timeout while nothing is ready, then a late ch1 grant
        pulse_reset();
        fifo_rden = 2'b00;
        adc_data = 16'h7E00;
        pmp_dreq = 1'b1;
        repeat (17) @(negedge clock);
        chk("t3_tmo_k16", pmp_timeout, 0);
        @(negedge clock);
        chk("t3_tmo_k17", pmp_timeout, 1);
        chk("t3_rdck_idle", fifo_rdck, 0);
        fifo_rden = 2'b10;
        wait_drdy(1'b1, "t3_drdy_rise");
        chk("t3_ch", pmp_ch, 1);
        chk("t3_d", pmp_d, 8'h7E);
        chk("t3_tmo_hold", pmp_timeout, 1);
        pmp_dreq = 1'b0;
        wait_drdy(1'b0, "t3_drdy_fall");
        chk("t3_tmo_clear", pmp_timeout, 0);

        // request dropped during the read clock pulse
        pulse_reset();
        fifo_rden = 2'b01;
        pmp_dreq = 1'b1;
        repeat (4) @(negedge clock);
        chk("t4_rdck_k3", fifo_rdck, 2'b01);
        pmp_dreq = 1'b0;
        @(negedge clock); chk("t4_rdck_k4", fifo_rdck, 2'b01);
        @(negedge clock); chk("t4_rdck_k5", fifo_rdck, 2'b00);
        repeat (2) @(negedge clock);
        chk("t4_drop_k7", drop_pulse, 1);
        chk("t4_drdy_k7", pmp_drdy, 0);
        @(negedge clock);
        chk("t4_drop_k8", drop_pulse, 0);
        chk("t4_cnt", xfer_count, 0);

        // reset during hold and during settle
        pulse_reset();
        fifo_rden = 2'b01;
        adc_data = 16'h0011;
        pmp_dreq = 1'b1;
        wait_drdy(1'b1, "t6_drdy_rise");
        #2 reset = 1'b1;
        pmp_dreq = 1'b0;
        #1;
        chk("t6_hold_drdy", pmp_drdy, 0);
        chk("t6_hold_d", pmp_d, 0);
        chk("t6_hold_cnt", xfer_count, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        fifo_rden = 2'b10;
        pmp_dreq = 1'b1;
        repeat (6) @(negedge clock);
        chk("t6_settle_rdck", fifo_rdck, 0);
        #2 reset = 1'b1;
        pmp_dreq = 1'b0;
        #1;
        chk("t6_rst_rdck", fifo_rdck, 0);
        chk("t6_rst_drdy", pmp_drdy, 0);
        chk("t6_rst_d", pmp_d, 0);
        chk("t6_rst_ch", pmp_ch, 0);
        chk("t6_rst_tmo", pmp_timeout, 0);
        chk("t6_rst_drop", drop_pulse, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        fifo_rden = 2'b11;
        pmp_dreq = 1'b1;
        wait_drdy(1'b1, "t6_after_rise");
        chk("t6_after_ch", pmp_ch, 0);
        pmp_dreq = 1'b0;
        wait_drdy(1'b0, "t6_after_fall");

        // randomized traffic with occasional resets
        pulse_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            adc_data = 16'($urandom);
            fifo_rden = ($urandom_range(0, 9) < 4) ? 2'($urandom) : 2'b00;
            if (pmp_dreq) pmp_dreq = ($urandom_range(0, 11) != 0);
            else pmp_dreq = ($urandom_range(0, 5) == 0);
            if (reset) #2 reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) #2 reset = 1'b1;
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
